muldiv_32: RTL and testbench
============================

MULDIV_32 -- requirements
Module: muldiv_32

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is required to work.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 Port: clock  in  1  rising-edge clock shared with the register file.
REQ-004 Port: reset_n  in  1  synchronous active-low reset.
REQ-005 Port: start  in  1  launch an operation; sampled only when busy=0.
REQ-006 Port: op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port: operand_s  in  32  rs value (register file outA); multiplicand or dividend.
REQ-008 Port: operand_t  in  32  rt value (register file outB); multiplier or divisor.
REQ-009 Port: write_hi  in  1  MTHI strobe.
REQ-010 Port: write_lo  in  1  MTLO strobe.
REQ-011 Port: write_data  in  32  data for MTHI/MTLO.
REQ-012 Port: busy  out  1  high while an operation is iterating.
REQ-013 Port: done  out  1  one-cycle completion pulse.
REQ-014 Port: div_by_zero  out  1  qualifies done; high when the completed DIV/DIVU had divisor 0.
REQ-015 Port: hi  out  32  HI register (MFHI source).
REQ-016 Port: lo  out  32  LO register (MFLO source).

Function
REQ-017 The state machine SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN: on start.
- RUN -> DONE: after WIDTH iterations.
- DONE -> IDLE: unconditionally, unless start is also asserted, in which case DONE -> RUN.
REQ-018 start SHALL be accepted in IDLE or DONE only; start while busy=1 SHALL be ignored, with operands and op discarded.
REQ-019 op, operand_s and operand_t SHALL be captured on the accepting edge N; later changes SHALL have no effect on the operation.
REQ-020 Timing: busy=1 for cycles N+1..N+WIDTH; hi/lo updated and done=1 in cycle N+WIDTH+1 only; busy=0 in DONE.
REQ-021 Iteration SHALL be radix-2, one bit per cycle:
- multiply: shift-add on operand magnitudes;
- divide: restoring on operand magnitudes.
REQ-022 MULT/MULTU SHALL produce the full 64-bit product: hi = bits 63:32, lo = bits 31:0.
- MULT: two's-complement signed.
- MULTU: unsigned.
REQ-023 DIV/DIVU SHALL give lo = quotient, hi = remainder.
- DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no flag.
REQ-025 Divide by zero (DIV/DIVU with operand_t=0):
- detected at acceptance; RUN is skipped;
- done=1 and div_by_zero=1 in cycle N+1;
- hi/lo unchanged.
REQ-026 div_by_zero SHALL be 0 whenever done=0, and 0 for multiplies.
REQ-027 write_hi/write_lo SHALL load write_data into hi/lo at the edge only when busy=0; when busy=1 they are ignored.
REQ-028 Simultaneous start and write_hi/write_lo SHALL apply the write at that edge; the later result overwrites it.
REQ-029 In the DONE cycle the operation result SHALL take precedence over a coincident write_hi/write_lo.
REQ-030 hi/lo SHALL hold their value in all cycles other than the update cases of REQ-020, REQ-027 and REQ-028.

Reset
REQ-031 reset_n=0 at a rising edge SHALL force:
- state IDLE;
- busy=0, done=0, div_by_zero=0;
- hi=0x00000000, lo=0x00000000;
- internal accumulators cleared.
REQ-032 reset_n=0 during RUN SHALL abort the operation; no done pulse shall follow, and results are discarded.
REQ-033 reset_n SHALL take precedence over start and write_hi/write_lo in the same cycle.
REQ-034 Between power-up and the first reset, output values are don't-care.

Verification
REQ-035 MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge N -> busy cycles N+1..N+32; done at N+33; hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; second case MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-037 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 Divide by zero: write_hi=0x12345678 and write_lo=0x9ABCDEF0, then DIV 5/0 -> done=div_by_zero=1 at N+1; hi/lo unchanged.
REQ-039 Busy interaction: second start plus write_hi during RUN -> ignored; first result intact. Back-to-back start in the DONE cycle -> second result at 33 cycles later.
REQ-040 Reset mid-operation: reset_n=0 at iteration 10 of MULTU -> next cycle busy=0, hi=lo=0; no done for 40 cycles after.

Source files
------------

// File: rtl/muldiv_32_if.sv
// muldiv_32_if: handshake and register-transfer bundle for the HI/LO
// multiply/divide unit.
//   start/op/operand_s/operand_t : launch an operation (op 00 MULT, 01 MULTU,
//                                  10 DIV, 11 DIVU)
//   write_hi/write_lo/write_data : MTHI/MTLO register writes
//   busy/done/div_by_zero        : iteration status and completion pulse
//   hi/lo                        : HI/LO register contents (MFHI/MFLO source)
// The master modport drives requests; the slave modport is the unit itself.
interface muldiv_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_s;
  logic [WIDTH-1:0] operand_t;
  logic             write_hi;
  logic             write_lo;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_s, operand_t, write_hi, write_lo, write_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_s, operand_t, write_hi, write_lo, write_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_32.sv
// muldiv_32: iterative radix-2 multiply/divide unit owning the HI and LO
// registers. Multiplies use shift-add and divides use restoring division, both
// on operand magnitudes, one bit per cycle; signs are fixed up when the result
// is written back.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : muldiv_32_if slave (start/op/operands, MTHI/MTLO writes,
//             busy/done/div_by_zero status, hi/lo registers)
module muldiv_32 #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  muldiv_32_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       op_q, op_d;
  // accHi holds the partial product upper half or the partial remainder;
  // accLo holds the multiplier being shifted out or the dividend/quotient.
  logic [WIDTH:0]   accHi_q, accHi_d;
  logic [WIDTH-1:0] accLo_q, accLo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             negRes_q, negRes_d;
  logic             negRem_q, negRem_d;
  logic             dbz_q, dbz_d;

  // Operand magnitudes and signs for the launching request.
  logic             isSigned, sNeg, tNeg, divZero;
  logic [WIDTH-1:0] magS, magT;

  always_comb begin
    isSigned = ~bus.op[0];
    sNeg     = isSigned & bus.operand_s[WIDTH-1];
    tNeg     = isSigned & bus.operand_t[WIDTH-1];
    magS     = sNeg ? (~bus.operand_s + 1'b1) : bus.operand_s;
    magT     = tNeg ? (~bus.operand_t + 1'b1) : bus.operand_t;
    divZero  = bus.op[1] & (bus.operand_t == '0);
  end

  // One iteration step. Multiply adds the multiplicand when the low multiplier
  // bit is set, then shifts {accHi, accLo} right. Divide shifts the next
  // dividend bit into the remainder and subtracts the divisor if it fits.
  logic [WIDTH:0]     addend, sum, shifted, diff;
  logic               fits;
  logic [WIDTH:0]     accHiIt;
  logic [WIDTH-1:0]   accLoIt;

  always_comb begin
    addend  = accLo_q[0] ? {1'b0, opnd_q} : '0;
    sum     = accHi_q + addend;
    shifted = {accHi_q[WIDTH-1:0], accLo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, opnd_q};
    diff    = shifted - {1'b0, opnd_q};
    if (op_q[1]) begin
      accHiIt = fits ? diff : shifted;
      accLoIt = {accLo_q[WIDTH-2:0], fits};
    end else begin
      accHiIt = {1'b0, sum[WIDTH:1]};
      accLoIt = {sum[0], accLo_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes. The remainder magnitude is
  // always below the divisor so it fits in WIDTH bits.
  logic [2*WIDTH-1:0] prodMag, prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    prodMag = {accHiIt[WIDTH-1:0], accLoIt};
    prod    = negRes_q ? (~prodMag + 1'b1) : prodMag;
    quo     = negRes_q ? (~accLoIt + 1'b1) : accLoIt;
    rem     = negRem_q ? (~accHiIt[WIDTH-1:0] + 1'b1) : accHiIt[WIDTH-1:0];
  end

  // Next-state logic. Writes and starts are honoured whenever the unit is not
  // iterating; a start in the DONE cycle chains straight into the next
  // operation. A zero divisor is caught at launch and goes directly to DONE
  // with the flag set and HI/LO untouched.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    accHi_d  = accHi_q;
    accLo_d  = accLo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    dbz_d    = dbz_q;
    case (state_q)
      RUN: begin
        accHi_d = accHiIt;
        accLo_d = accLoIt;
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = DONE;
          dbz_d   = 1'b0;
          if (op_q[1]) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.write_hi) hi_d = bus.write_data;
        if (bus.write_lo) lo_d = bus.write_data;
        if (bus.start) begin
          op_d = bus.op;
          if (divZero) begin
            state_d = DONE;
            dbz_d   = 1'b1;
          end else begin
            state_d  = RUN;
            dbz_d    = 1'b0;
            count_d  = '0;
            accHi_d  = '0;
            negRes_d = sNeg ^ tNeg;
            negRem_d = sNeg;
            accLo_d  = bus.op[1] ? magS : magT;
            opnd_d   = bus.op[1] ? magT : magS;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      accHi_q  <= '0;
      accLo_q  <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      accHi_q  <= accHi_d;
      accLo_q  <= accLo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = (state_q == DONE) & dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_32.sv
// tb_muldiv_32: self-checking bench for muldiv_32. A cycle-level behavioural
// model computes results with plain 64-bit arithmetic and is compared against
// the DUT outputs every cycle; directed cases pin literal results and timing.
module tb_muldiv_32;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic clock = 1'b0;
  logic reset_n;
  int   totalChecks = 0;
  int   passCount = 0;

  always #5 clock = ~clock;

  muldiv_32_if #(.WIDTH(32)) bus ();

  muldiv_32 #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    totalChecks++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
  endtask

  // Reference arithmetic straight from the operation definitions.
  task automatic modelResult(input logic [1:0] o, input logic [31:0] s,
                             input logic [31:0] t, output logic [31:0] rHi,
                             output logic [31:0] rLo);
    longint a, b, q, r, p;
    logic [63:0] bits;
    case (o)
      MULT: begin
        a = longint'($signed(s)); b = longint'($signed(t)); p = a * b;
        bits = p;
      end
      MULTU: begin
        a = longint'({32'b0, s}); b = longint'({32'b0, t}); p = a * b;
        bits = p;
      end
      DIV: begin
        a = longint'($signed(s)); b = longint'($signed(t));
        q = a / b; r = a % b;
        bits = {r[31:0], q[31:0]};
      end
      default: begin
        a = longint'({32'b0, s}); b = longint'({32'b0, t});
        q = a / b; r = a % b;
        bits = {r[31:0], q[31:0]};
      end
    endcase
    rHi = bits[63:32];
    rLo = bits[31:0];
  endtask

  // Model state.
  bit          modelValid = 1'b0;
  int          busyLeft = 0;
  bit          expDone = 1'b0, expDbz = 1'b0;
  logic [31:0] expHi = '0, expLo = '0, pendHi = '0, pendLo = '0;

  // Capture the inputs seen at each rising edge, advance the model, then
  // compare all outputs once they have settled.
  always @(posedge clock) begin
    logic        rn, st, wh, wl;
    logic [1:0]  o;
    logic [31:0] s, t, wd;
    rn = reset_n; st = bus.start; o = bus.op; s = bus.operand_s;
    t = bus.operand_t; wh = bus.write_hi; wl = bus.write_lo; wd = bus.write_data;
    #1;
    if (!rn) begin
      modelValid = 1'b1; busyLeft = 0; expDone = 1'b0; expDbz = 1'b0;
      expHi = '0; expLo = '0;
    end else if (modelValid) begin
      expDone = 1'b0; expDbz = 1'b0;
      if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) begin
          expDone = 1'b1; expHi = pendHi; expLo = pendLo;
        end
      end else begin
        if (wh) expHi = wd;
        if (wl) expLo = wd;
        if (st) begin
          if (o[1] && t == 32'd0) begin
            expDone = 1'b1; expDbz = 1'b1;
          end else begin
            modelResult(o, s, t, pendHi, pendLo);
            busyLeft = 32;
          end
        end
      end
    end
    if (modelValid)
      checkOutput("cycle busy/done/dbz/hi/lo",
                  {bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo},
                  {(busyLeft > 0), expDone, expDbz, expHi, expLo});
  end

  // Launch one operation; returns half-way through cycle N+1 with the operand
  // inputs scrambled to prove they were captured at acceptance.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] s,
                               input logic [31:0] t);
    @(negedge clock);
    bus.start = 1'b1; bus.op = o; bus.operand_s = s; bus.operand_t = t;
    @(negedge clock);
    bus.start = 1'b0; bus.op = 2'($urandom);
    bus.operand_s = $urandom; bus.operand_t = $urandom;
  endtask

  // Counts cycles after acceptance until done, bounded.
  task automatic waitDone(input int startN, output int n);
    n = startN;
    while (!bus.done && n < 60) begin
      @(posedge clock); #1; n++;
    end
    checkOutput("done seen before timeout", bus.done, 1'b1);
  endtask

  task automatic directedOp(input string name, input logic [1:0] o,
                            input logic [31:0] s, input logic [31:0] t,
                            input logic [31:0] eHi, input logic [31:0] eLo,
                            input int eCycles, input logic eDbz);
    int n;
    applyStimulus(o, s, t);
    waitDone(1, n);
    checkOutput({name, " latency"}, n, eCycles);
    checkOutput({name, " hi"}, bus.hi, eHi);
    checkOutput({name, " lo"}, bus.lo, eLo);
    checkOutput({name, " div_by_zero"}, bus.div_by_zero, eDbz);
  endtask

  task automatic writeReg(input bit toHi, input logic [31:0] d);
    @(negedge clock);
    bus.write_hi = toHi; bus.write_lo = ~toHi; bus.write_data = d;
    @(negedge clock);
    bus.write_hi = 1'b0; bus.write_lo = 1'b0;
  endtask

  initial begin
    logic [31:0] mh, ml;
    logic [31:0] special [5];
    int n, doneSeen;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.operand_s = '0; bus.operand_t = '0;
    bus.write_hi = 1'b0; bus.write_lo = 1'b0; bus.write_data = '0;

    // Pin the model on literal cases.
    modelResult(MULT, 32'hFFFFFFFD, 32'd7, mh, ml);
    checkOutput("model MULT -3*7", {mh, ml}, 64'hFFFFFFFF_FFFFFFEB);
    modelResult(DIV, 32'h80000000, 32'hFFFFFFFF, mh, ml);
    checkOutput("model DIV min/-1", {mh, ml}, 64'h00000000_80000000);
    modelResult(DIV, 32'hFFFFFFF9, 32'd2, mh, ml);
    checkOutput("model DIV -7/2", {mh, ml}, 64'hFFFFFFFF_FFFFFFFD);

    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("reset state", {bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo}, '0);

    directedOp("MULTU max*max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 33, 1'b0);
    directedOp("MULT -3*7", MULT, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0);
    directedOp("MULT min*min", MULT, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 33, 1'b0);
    directedOp("DIV -7/2", DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    directedOp("DIVU 7/2", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 33, 1'b0);
    directedOp("DIV min/-1", DIV, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 33, 1'b0);

    writeReg(1'b1, 32'h12345678);
    writeReg(1'b0, 32'h9ABCDEF0);
    directedOp("DIV 5/0", DIV, 32'd5, 32'd0, 32'h12345678, 32'h9ABCDEF0, 1, 1'b1);

    // Start and MTHI while busy are ignored.
    applyStimulus(MULTU, 32'd6, 32'd7);
    repeat (3) @(negedge clock);
    bus.start = 1'b1; bus.op = DIVU; bus.operand_s = 32'd1; bus.operand_t = 32'd0;
    bus.write_hi = 1'b1; bus.write_data = 32'hDEADBEEF;
    @(negedge clock);
    bus.start = 1'b0; bus.write_hi = 1'b0;
    waitDone(5, n);
    checkOutput("busy intrusion latency", n, 33);
    checkOutput("busy intrusion result", {bus.hi, bus.lo}, 64'd42);

    // Back-to-back start in the DONE cycle.
    bus.start = 1'b1; bus.op = DIVU; bus.operand_s = 32'd100; bus.operand_t = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    waitDone(1, n);
    checkOutput("chained DIVU latency", n, 33);
    checkOutput("chained DIVU result", {bus.hi, bus.lo}, {32'd2, 32'd14});

    // Reset at iteration 10 aborts the operation.
    applyStimulus(MULTU, 32'hCAFEF00D, 32'h12345);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    checkOutput("abort state", {bus.busy, bus.hi, bus.lo}, '0);
    @(negedge clock);
    reset_n = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (bus.done) doneSeen++;
    end
    checkOutput("no done after abort", doneSeen, 0);

    // Random traffic; the per-cycle model does the checking.
    special[0] = 32'h80000000; special[1] = 32'hFFFFFFFF;
    special[2] = 32'h00000000; special[3] = 32'h00000001;
    special[4] = 32'h7FFFFFFF;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clock);
      bus.start      = ($urandom_range(0, 2) == 0);
      bus.op         = 2'($urandom);
      bus.operand_s  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      bus.operand_t  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 5) == 0) bus.operand_t = 32'($urandom_range(1, 9));
      bus.write_hi   = ($urandom_range(0, 3) == 0);
      bus.write_lo   = ($urandom_range(0, 3) == 0);
      bus.write_data = $urandom;
      reset_n        = ($urandom_range(0, 599) != 0);
    end
    @(negedge clock);
    bus.start = 1'b0; bus.write_hi = 1'b0; bus.write_lo = 1'b0; reset_n = 1'b1;
    repeat (40) @(negedge clock);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
